// File: rtl/overlap_add_sequencer.sv
// overlap_add_sequencer: row/column sequencer for an overlap-add convolution datapath.
// Ports: start/abort control a frame; in_valid/in_ready handshake upstream row-product beats;
//        en_shift/data_strobe drive the datapath; accumn_fin returns the row-finished flag;
//        row_valid/row_idx/frame_done/busy/err report progress and status.
// Latency: strobes are combinational with the accepted beat; row_valid is registered, one
//          cycle after accumn_fin is seen in WAIT_FIN.
// Backpressure: in_ready is high only in FEED; upstream stalls (in_valid=0) hold the column.
module overlap_add_sequencer #(
  parameter int N_COL_FEATURE = 8,
  parameter int N_COL_KERNEL  = 5,
  parameter int N_ROW_FEATURE = 8,
  parameter int FIN_TIMEOUT   = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             en_shift,
  output logic [N_COL_FEATURE-1:0]         data_strobe,
  input  logic                             accumn_fin,
  output logic                             row_valid,
  output logic [$clog2(N_ROW_FEATURE)-1:0] row_idx,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             err
);

  localparam int CW = (N_COL_FEATURE > 1) ? $clog2(N_COL_FEATURE) : 1;
  localparam int RW = $clog2(N_ROW_FEATURE);
  localparam int WW = $clog2(FIN_TIMEOUT + 1);
  localparam int HW = $clog2(N_COL_KERNEL + 1);

  localparam logic [CW-1:0] COL_LAST  = CW'(N_COL_FEATURE - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(N_ROW_FEATURE - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(FIN_TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(N_COL_KERNEL - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FEED     = 3'd1,
    S_WAIT_FIN = 3'd2,
    S_HOLD     = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  state_e         state_q,      state_d;
  logic [CW-1:0]  col_idx_q,    col_idx_d;
  logic [RW-1:0]  row_idx_q,    row_idx_d;
  logic [WW-1:0]  wait_cnt_q,   wait_cnt_d;
  logic [HW-1:0]  hold_cnt_q,   hold_cnt_d;
  logic           row_valid_q,  row_valid_d;
  logic           frame_done_q, frame_done_d;
  logic           err_q,        err_d;

  // ------------------------------------------------------------------
  // Combinational outputs derived from the registered state. Because
  // they depend only on state_q (and in_valid), an asynchronous reset
  // forces them low immediately.
  // ------------------------------------------------------------------
  always_comb begin
    in_ready    = (state_q == S_FEED);
    en_shift    = in_valid & in_ready;
    data_strobe = '0;
    if (en_shift) begin
      data_strobe[col_idx_q] = 1'b1;
    end
    busy        = (state_q != S_IDLE);
  end

  assign row_valid  = row_valid_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign row_idx    = row_idx_q;

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    col_idx_d    = col_idx_q;
    row_idx_d    = row_idx_q;
    wait_cnt_d   = wait_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    row_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FEED;
          col_idx_d = '0;
          row_idx_d = '0;
          err_d     = 1'b0;
        end
      end

      S_FEED: begin
        if (en_shift) begin
          if (col_idx_q == COL_LAST) begin
            col_idx_d  = '0;
            wait_cnt_d = '0;
            state_d    = S_WAIT_FIN;
          end else begin
            col_idx_d = col_idx_q + 1'b1;
          end
        end
      end

      S_WAIT_FIN: begin
        // accumn_fin wins over the timeout when both land on the last
        // allowed cycle, so a late-but-in-time finish is never an error.
        if (accumn_fin) begin
          row_valid_d = 1'b1;
          hold_cnt_d  = HOLD_LOAD;
          wait_cnt_d  = '0;
          state_d     = S_HOLD;
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_d      = 1'b1;
          wait_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_HOLD: begin
        // hold_cnt_q counts the HOLD cycles still to run, this one
        // included; the exit cycle is the one whose decrement hits 0.
        if (hold_cnt_q <= HW'(1)) begin
          hold_cnt_d = '0;
          if (row_idx_q == ROW_LAST) begin
            frame_done_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            row_idx_d = row_idx_q + 1'b1;
            state_d   = S_FEED;
          end
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything above; the sticky error is preserved.
    if (abort) begin
      state_d      = S_IDLE;
      col_idx_d    = '0;
      row_idx_d    = '0;
      wait_cnt_d   = '0;
      hold_cnt_d   = '0;
      row_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      err_d        = err_q;
    end
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      col_idx_q    <= '0;
      row_idx_q    <= '0;
      wait_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      row_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_idx_q    <= col_idx_d;
      row_idx_q    <= row_idx_d;
      wait_cnt_q   <= wait_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      row_valid_q  <= row_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_overlap_add_sequencer.sv
// tb_overlap_add_sequencer: randomized scoreboard bench for overlap_add_sequencer.
// Stimulus pushes the expected event stream (strobe per column, row_valid per row,
// frame_done / err); a negedge monitor pops and compares whenever the DUT emits one.
module tb_overlap_add_sequencer;

  localparam int NCF = 8;
  localparam int NCK = 5;
  localparam int NRF = 8;
  localparam int FTO = 16;
  localparam int RW  = $clog2(NRF);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           in_valid = 1'b0;
  logic           accumn_fin = 1'b0;
  logic           in_ready, en_shift, row_valid, busy, frame_done, err;
  logic [NCF-1:0] data_strobe;
  logic [RW-1:0]  row_idx;

  always #5 clk = ~clk;

  overlap_add_sequencer #(
    .N_COL_FEATURE(NCF), .N_COL_KERNEL(NCK), .N_ROW_FEATURE(NRF), .FIN_TIMEOUT(FTO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .en_shift(en_shift),
    .data_strobe(data_strobe), .accumn_fin(accumn_fin), .row_valid(row_valid),
    .row_idx(row_idx), .busy(busy), .frame_done(frame_done), .err(err)
  );

  typedef enum int {EV_STROBE, EV_ROWV, EV_DONE, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       row;
    int       col;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic push(input ev_kind_e k, input int r, input int c);
    ev_t e;
    e.kind = k; e.row = r; e.col = c;
    exp_q.push_back(e);
  endtask

  // Pops the next expected event; an empty queue means the DUT emitted something unexpected.
  task automatic pop_expect(input ev_kind_e k, output ev_t e, output bit ok);
    ok = 1'b0;
    e.kind = EV_STROBE; e.row = 0; e.col = 0;
    if (exp_q.size() == 0) begin
      chk($sformatf("unexpected_event_kind%0d", int'(k)), 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", int'(k), int'(e.kind));
      ok = (e.kind == k);
    end
  endtask

  // ---------------- monitor ----------------
  bit err_prev = 1'b0;
  bit rv_pend  = 1'b0;
  int rv_cyc   = 0;

  initial begin
    ev_t            e;
    bit             ok;
    logic [NCF-1:0] s;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n || abort) rv_pend = 1'b0;
      if (en_shift) begin
        pop_expect(EV_STROBE, e, ok);
        if (ok) begin
          s = '0;
          s[e.col] = 1'b1;
          chk($sformatf("strobe_r%0d_c%0d", e.row, e.col), data_strobe, s);
          chk($sformatf("row_idx_r%0d_c%0d", e.row, e.col), row_idx, e.row);
        end
      end else begin
        chk("strobe_zero_when_idle", data_strobe, '0);
      end
      if (row_valid) begin
        pop_expect(EV_ROWV, e, ok);
        if (ok) chk($sformatf("row_valid_idx_r%0d", e.row), row_idx, e.row);
        rv_pend = 1'b1;
        rv_cyc  = cyc;
      end else if (rv_pend && (in_ready || frame_done)) begin
        // row_valid sits in the first HOLD cycle, so the next FEED/DONE is NCK-1 later
        chk("hold_length", cyc - rv_cyc, NCK - 1);
        rv_pend = 1'b0;
      end
      if (frame_done) pop_expect(EV_DONE, e, ok);
      if (err && !err_prev) pop_expect(EV_ERR, e, ok);
      err_prev = err;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("err_cleared_by_start", err, 1'b0);
  endtask

  // mode: 0 = in_valid held high, 1 = toggled 1,0,1,0, 2 = random
  task automatic feed_row(input int r, input int nbeats, input int mode, input bit noise);
    int beats;
    int cycles;
    beats  = 0;
    cycles = 0;
    for (int c = 0; c < nbeats; c++) push(EV_STROBE, r, c);
    while (beats < nbeats && cycles < 500) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cycles % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      accumn_fin = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      start      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #3;
      if (in_valid && in_ready) beats++;
      cycles++;
      tick();
    end
    in_valid = 1'b0; accumn_fin = 1'b0; start = 1'b0;
    chk("feed_beats_accepted", beats, nbeats);
    if (mode == 0) chk("feed_consecutive_cycles", cycles, nbeats);
  endtask

  task automatic wait_fin(input int r, input int k);
    accumn_fin = 1'b0;
    for (int i = 0; i < k; i++) tick();
    accumn_fin = 1'b1;
    push(EV_ROWV, r, 0);
    tick();
    accumn_fin = 1'b0;
  endtask

  task automatic hold(input bit noise);
    for (int i = 0; i < NCK - 1; i++) begin
      accumn_fin = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    accumn_fin = 1'b0;
  endtask

  // fixed_k < 0 picks a random in-time finish for each row
  task automatic run_frame(input int mode, input bit noise, input int fixed_k);
    int k;
    begin_frame();
    for (int r = 0; r < NRF; r++) begin
      feed_row(r, NCF, mode, noise);
      k = (fixed_k >= 0) ? fixed_k : int'($urandom_range(0, FTO - 1));
      wait_fin(r, k);
      hold(noise);
    end
    push(EV_DONE, 0, 0);
    chk("frame_done_in_done", frame_done, 1'b1);
    chk("row_idx_last", row_idx, NRF - 1);
    tick();
    chk("frame_done_one_cycle", frame_done, 1'b0);
    chk("busy_after_done", busy, 1'b0);
    chk("row_idx_kept_after_done", row_idx, NRF - 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_en_shift"}, en_shift, 1'b0);
    chk({tag, "_strobe"}, data_strobe, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_row_valid"}, row_valid, 1'b0);
    chk({tag, "_frame_done"}, frame_done, 1'b0);
  endtask

  initial begin
    #1;
    chk_all_zero("reset");
    chk("reset_err", err, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // held-high beats, finish one cycle after WAIT_FIN entry
    run_frame(0, 1'b0, 1);
    // toggled in_valid
    run_frame(1, 1'b0, -1);
    // random stalls with stray accumn_fin/start outside WAIT_FIN
    run_frame(2, 1'b1, -1);
    // finish on the last in-time WAIT_FIN cycle
    run_frame(0, 1'b1, FTO - 1);

    // timeout: accumn_fin never arrives
    begin_frame();
    feed_row(0, NCF, 0, 1'b0);
    push(EV_ERR, 0, 0);
    for (int i = 0; i < FTO - 1; i++) tick();
    chk("timeout_not_early_busy", busy, 1'b1);
    chk("timeout_not_early_err", err, 1'b0);
    tick();
    chk("timeout_err", err, 1'b1);
    chk("timeout_busy", busy, 1'b0);
    chk("timeout_in_ready", in_ready, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_keeps_err", err, 1'b1);

    // abort at row 3, column 5
    begin_frame();
    for (int r = 0; r < 3; r++) begin
      feed_row(r, NCF, 0, 1'b0);
      wait_fin(r, int'($urandom_range(0, FTO - 1)));
      hold(1'b0);
    end
    feed_row(3, 5, 0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_in_ready", in_ready, 1'b0);
    repeat (6) tick();
    chk("abort_no_pending", exp_q.size(), 0);
    run_frame(2, 1'b0, -1);

    // reset asserted mid-HOLD
    begin_frame();
    feed_row(0, NCF, 0, 1'b0);
    wait_fin(0, 2);
    tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset_mid_hold");
    chk("reset_mid_hold_err", err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) tick();
    chk("after_reset_busy", busy, 1'b0);
    chk("after_reset_no_pending", exp_q.size(), 0);
    run_frame(2, 1'b1, -1);

    repeat (5) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/overlap_add_sequencer.md
OVERLAP_ADD_SEQUENCER -- requirements
Module: overlap_add_sequencer

Interface
REQ-001 SHALL have parameter N_COL_FEATURE, default 8: feature columns per row, which is also the beat count per row.
REQ-002 SHALL have parameter N_COL_KERNEL, default 5: kernel columns; the hold-off after each row lasts N_COL_KERNEL-1 cycles.
REQ-003 SHALL have parameter N_ROW_FEATURE, default 8: rows per frame.
REQ-004 SHALL have parameter FIN_TIMEOUT, default 16: maximum WAIT_FIN cycles before an error is declared.
REQ-005 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit: begin a frame; sampled only in IDLE.
REQ-008 SHALL have port abort, input, 1 bit: synchronous return to IDLE from any state.
REQ-009 SHALL have port in_valid, input, 1 bit: upstream row-product beat is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: sequencer accepts a beat.
REQ-011 SHALL have port en_shift, output, 1 bit: shift/accumulate enable to the overlap-add datapath.
REQ-012 SHALL have port data_strobe, output, N_COL_FEATURE bits: one-hot column-slice select to the datapath.
REQ-013 SHALL have port accumn_fin, input, 1 bit: datapath row-accumulation-finished flag.
REQ-014 SHALL have port row_valid, output, 1 bit: one-cycle pulse marking an accumulated row as available.
REQ-015 SHALL have port row_idx, output, $clog2(N_ROW_FEATURE) bits: index of the current row.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-017 SHALL have port frame_done, output, 1 bit: one-cycle pulse on frame completion.
REQ-018 SHALL have port err, output, 1 bit: sticky timeout flag.

Function
REQ-019 SHALL implement the states IDLE, FEED, WAIT_FIN, HOLD and DONE, encoded in registered state.
REQ-020 SHALL go IDLE->FEED when start=1 and clear col_idx, row_idx and err on that transition.
REQ-021 SHALL drive in_ready=1 only in FEED, combinationally from state.
REQ-022 SHALL drive en_shift = in_valid & in_ready combinationally, so it is aligned with the datapath input word.
REQ-023 SHALL drive data_strobe = en_shift ? (1<<col_idx) : 0, so it is exactly one-hot on an accepted beat and zero otherwise.
REQ-024 SHALL, on an accepted beat, increment col_idx; when the accepted beat has col_idx=N_COL_FEATURE-1, col_idx wraps to 0 and state goes to WAIT_FIN.
REQ-025 SHALL hold col_idx and keep en_shift=0 in FEED while in_valid=0, so upstream stalls are tolerated.
REQ-026 SHALL, in WAIT_FIN, count cycles starting at 0; on accumn_fin=1, register row_valid=1 for exactly the next cycle and go to HOLD.
REQ-027 SHALL, if the WAIT_FIN count reaches FIN_TIMEOUT with accumn_fin=0, set err=1 (sticky until next start or reset) and go to IDLE.
REQ-028 SHALL load a counter with N_COL_KERNEL-1 on HOLD entry and decrement it each cycle; at 0 it exits HOLD.
REQ-029 SHALL keep in_ready=0 and en_shift=0 in HOLD, covering the datapath's continuation window.
REQ-030 SHALL, on HOLD exit, go to DONE if row_idx=N_ROW_FEATURE-1, otherwise increment row_idx and go to FEED.
REQ-031 SHALL pulse frame_done=1 for one cycle in DONE, then go to IDLE; row_idx remains at its last value until the next start.
REQ-032 SHALL give abort priority over every transition: next state IDLE, counters cleared, err unchanged, and no row_valid or frame_done pulse.
REQ-033 SHALL ignore accumn_fin outside WAIT_FIN.
REQ-034 SHALL ignore start outside IDLE.
REQ-035 SHALL let accumn_fin take priority if it arrives in the same cycle the timeout is reached: no err, go to HOLD.

Reset
REQ-036 SHALL, on rst_n=0, asynchronously force state=IDLE and clear col_idx, row_idx, the WAIT_FIN and HOLD counters, row_valid, frame_done and err.
REQ-037 SHALL, during and after reset, present in_ready=0, en_shift=0, data_strobe=0 and busy=0.
REQ-038 SHALL, when reset is asserted mid-frame, discard all progress; the next start begins at row 0, column 0.

Verification
REQ-039 SHALL pass: defaults, start, in_valid held high, accumn_fin asserted 1 cycle after WAIT_FIN entry -> per row, strobes 0x01..0x80 on consecutive cycles, row_valid once, 4 HOLD cycles; 8 rows, then frame_done one cycle.
REQ-040 SHALL pass: in_valid toggled 1,0,1,0 during FEED -> exactly 8 strobes per row, no column skipped or repeated.
REQ-041 SHALL pass: accumn_fin never asserted -> err=1 after 16 WAIT_FIN cycles, state IDLE, busy=0.
REQ-042 SHALL pass: abort at row 3, column 5 -> IDLE next cycle, no frame_done; next start strobes 0x01 at row_idx=0.
REQ-043 SHALL pass: rst_n low mid-HOLD -> all outputs 0 immediately, no row_valid after release.
REQ-044 SHALL pass: accumn_fin pulsed during FEED and HOLD -> ignored, sequence unchanged.
